// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level constants
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: a prescale counter that wraps once per
// bit period, plus the payload bit index that advances on each wrap.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  idx_en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_done_o,
  output logic                  last_bit_o,
  output logic [IDX_W-1:0]      bit_idx_o
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrap;

  // prescale_i is never zero while enabled: the top latches 0 as 1
  assign wrap = en_i && (cnt_q == (prescale_i - PRE_ONE));

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clear_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : (cnt_q + PRE_ONE);
      if (wrap && idx_en_i) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_ONE);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign bit_done_o = wrap;
  assign last_bit_o = (idx_q == IDX_LAST);
  assign bit_idx_o  = idx_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a parallel byte and serialises one frame
// (start, data LSB-first, optional parity, stop) with a registered TX_OUT.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]      IDX_ONE = IDX_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  uart_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  bit_done;
  logic                  last_bit;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  par_bit;

  assign accept  = (state_q == IDLE) && Data_Valid;
  assign par_bit = (^data_q) ^ (par_typ_q == PAR_ODD);

  uart_tx_bit_timer #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRESCALE_W(PRESCALE_W),
    .IDX_W     (IDX_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .en_i      (state_q != IDLE),
    .idx_en_i  (state_q == DATA),
    .prescale_i(prescale_q),
    .bit_done_o(bit_done),
    .last_bit_o(last_bit),
    .bit_idx_o (bit_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Frame fields are frozen at accept so mid-frame input changes are harmless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else if (accept) begin
      data_q     <= P_DATA;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
      prescale_q <= (Prescale == '0) ? PRE_ONE : Prescale;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Data_Valid) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output is registered, so the mux looks at the state being entered
  always_comb begin
    next_idx = bit_idx;
    if ((state_q == DATA) && bit_done) begin
      next_idx = bit_idx + IDX_ONE;
    end
    tx_d   = STOP_BIT;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    tx_d = STOP_BIT;
      START:   tx_d = START_BIT;
      DATA:    tx_d = data_q[next_idx];
      PARITY:  tx_d = par_bit;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
